rx_pkt_assembler: RTL and testbench
===================================

Name: rx_pkt_assembler

Overview:
- Downstream consumer of the UART receive block.
- Drains received bytes through the rx_data / data_ready / data_read handshake and hunts for a sync byte.
- Assembles fixed-length command frames: sync, opcode, PAYLOAD_BYTES payload bytes, XOR checksum.
- Presents each verified frame on a valid/ready interface to the master/slave command logic.
- Aborts cleanly on line errors and checksum mismatch.

Parameters:
- PAYLOAD_BYTES, 4, payload bytes per frame; legal range 1..16.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles; used only when RX_PKT_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from the UART receive buffer
- data_ready  in  1  byte available in the receive buffer
- overrun_error  in  1  receive-buffer overrun flag
- framing_error  in  1  stop-bit error flag
- data_read  out  1  one-cycle pulse acknowledging a consumed byte
- pkt_opcode  out  8  opcode of the held frame
- pkt_payload  out  8*PAYLOAD_BYTES  payload; first received byte in bits [7:0]
- pkt_valid  out  1  verified frame held
- pkt_ready  in  1  consumer accepts the frame
- chk_error  out  1  one-cycle pulse on checksum mismatch
- err_abort  out  1  one-cycle pulse on frame abort (line error or timeout)

Behaviour:
- Single clock domain. Asynchronous active-low reset (n_rst) returns state to IDLE and clears counters.
- Reset values: data_read=0, pkt_valid=0, chk_error=0, err_abort=0, pkt_opcode=0, pkt_payload=0.
- Reset mid-frame discards the partial frame.
- Byte capture: a byte is captured at the clock edge where data_ready=1, data_read=0, and state is not HOLD.
- data_read is registered. It is high for exactly the one cycle after each capture.
  - The data_read=0 term blocks double capture while the buffer clears data_ready.
- States:
  - IDLE: captured byte == SYNC_BYTE -> OPCODE. Any other byte is discarded and the state stays IDLE. Line errors in IDLE raise no err_abort.
  - OPCODE: capture -> pkt_opcode; running checksum = byte; byte counter cleared -> PAYLOAD.
  - PAYLOAD: capture -> payload lane [counter]; checksum ^= byte; counter++. After PAYLOAD_BYTES bytes -> CHECK.
  - CHECK: captured byte == checksum -> HOLD with pkt_valid=1 on the next cycle. Otherwise chk_error pulses for 1 cycle -> IDLE.
  - HOLD: pkt_valid=1. pkt_opcode and pkt_payload are stable. No bytes are consumed (backpressure; upstream overrun is then possible and is not this block's concern).
    - pkt_valid & pkt_ready high at an edge -> transfer. pkt_valid=0 the next cycle -> IDLE.
- Errors in OPCODE, PAYLOAD or CHECK: overrun_error or framing_error sampled high -> err_abort pulses for 1 cycle -> IDLE.
  - If a byte is captured in the same cycle, it is still acknowledged (data_read pulses) and discarded; the error wins.
  - Errors are ignored in HOLD; the held frame stays valid.
- Width rules:
  - Checksum is 8-bit XOR of opcode and all payload bytes.
  - Byte counter width is $clog2(PAYLOAD_BYTES+1).
  - The counter never wraps inside a frame.
- A SYNC_BYTE value arriving inside OPCODE, PAYLOAD or CHECK is treated as ordinary data (no resync).
- Latency: pkt_valid rises on the cycle after the checksum byte is captured.

Optional Feature:
- Macro: RX_PKT_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in OPCODE, PAYLOAD or CHECK. It clears on each capture and on state entry.
  - Reaching TIMEOUT_CYCLES cycles without a capture -> err_abort pulse -> IDLE.
- Undefined: no counter is built. A partial frame waits indefinitely for its remaining bytes.

Test Plan:
- Bytes A5 10 01 02 03 04 14 -> pkt_valid=1, pkt_opcode=0x10, pkt_payload=0x04030201, chk_error=0. Seven data_read pulses, one per byte.
- Same frame with checksum 15 -> chk_error single pulse after the 7th byte; pkt_valid stays 0; state returns to IDLE.
- Bytes 00 FF A5 then a valid frame body -> 00 and FF discarded; frame accepted; data_read pulses once per byte, no double acknowledgement.
- framing_error=1 during the 2nd payload byte -> err_abort pulse, no pkt_valid. A following good frame is accepted normally.
- pkt_ready held 0 for 50 cycles after pkt_valid while the next byte waits -> outputs stable, data_read stays 0. Raising pkt_ready -> one transfer, then the pending byte is consumed.
- TIMEOUT_CYCLES=100: stop sending after the opcode.
  - With RX_PKT_TIMEOUT_EN -> err_abort 100 cycles after the last capture.
  - Without it -> state holds and no pulse; n_rst asserted mid-frame clears to IDLE with all outputs at reset values.

Source files
------------

// File: rtl/rx_pkt_assembler_if.sv
// Byte-receive and frame-hand-off bundle for rx_pkt_assembler.
// master: the assembler (drains the UART buffer, offers frames).
// slave : the environment (UART receive buffer plus command consumer).
interface rx_pkt_assembler_if #(
    parameter int PAYLOAD_BYTES = 4
);
    logic [7:0]                 rx_data;
    logic                       data_ready;
    logic                       overrun_error;
    logic                       framing_error;
    logic                       data_read;
    logic [7:0]                 pkt_opcode;
    logic [8*PAYLOAD_BYTES-1:0] pkt_payload;
    logic                       pkt_valid;
    logic                       pkt_ready;
    logic                       chk_error;
    logic                       err_abort;

    modport master (
        input  rx_data, data_ready, overrun_error, framing_error, pkt_ready,
        output data_read, pkt_opcode, pkt_payload, pkt_valid, chk_error, err_abort
    );

    modport slave (
        output rx_data, data_ready, overrun_error, framing_error, pkt_ready,
        input  data_read, pkt_opcode, pkt_payload, pkt_valid, chk_error, err_abort
    );
endinterface

// File: rtl/rx_pkt_assembler.sv
// rx_pkt_assembler: hunts for SYNC_BYTE in the UART byte stream, assembles
// sync/opcode/payload/XOR-checksum frames and holds each verified frame on a
// valid/ready interface. Line errors abort a partial frame; a bad checksum
// drops it.
// Optional feature macro RX_PKT_TIMEOUT_EN: aborts a partial frame after
// TIMEOUT_CYCLES cycles without a received byte. Without it a partial frame
// waits indefinitely.
module rx_pkt_assembler #(
    parameter int         PAYLOAD_BYTES  = 4,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               n_rst,
    rx_pkt_assembler_if.master bus
);
    localparam int              CNT_W    = $clog2(PAYLOAD_BYTES + 1);
    localparam int              PW       = 8 * PAYLOAD_BYTES;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPCODE  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_data_read;
    logic             r_pkt_valid;
    logic             r_chk_error;
    logic             r_err_abort;
    logic [7:0]       r_pkt_opcode;
    logic [PW-1:0]    r_pkt_payload;
    logic [7:0]       r_chksum;
    logic [CNT_W-1:0] r_cnt;

    logic             w_pkt_valid;
    logic             w_chk_error;
    logic             w_err_abort;
    logic [7:0]       w_pkt_opcode;
    logic [PW-1:0]    w_pkt_payload;
    logic [7:0]       w_chksum;
    logic [CNT_W-1:0] w_cnt;
    logic             w_capture;
    logic             w_line_err;
    logic             w_timeout;

    // The data_read term stops a second capture while the buffer drops data_ready.
    assign w_capture  = bus.data_ready & ~r_data_read & (r_state != HOLD);
    assign w_line_err = bus.overrun_error | bus.framing_error;

`ifdef RX_PKT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_in_frame;

    assign w_in_frame = (r_state == OPCODE) | (r_state == PAYLOAD) | (r_state == CHECK);
    assign w_timeout  = w_in_frame & ~w_capture & (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Idle-line cycle counter: restarts on every capture and every state change.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tmo_cnt <= '0;
        end else if (!w_in_frame || w_capture || (w_next_state != r_state)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    // State and datapath registers; every output is driven from a flop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= IDLE;
            r_data_read   <= 1'b0;
            r_pkt_valid   <= 1'b0;
            r_chk_error   <= 1'b0;
            r_err_abort   <= 1'b0;
            r_pkt_opcode  <= 8'h00;
            r_pkt_payload <= '0;
            r_chksum      <= 8'h00;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_next_state;
            r_data_read   <= w_capture;
            r_pkt_valid   <= w_pkt_valid;
            r_chk_error   <= w_chk_error;
            r_err_abort   <= w_err_abort;
            r_pkt_opcode  <= w_pkt_opcode;
            r_pkt_payload <= w_pkt_payload;
            r_chksum      <= w_chksum;
            r_cnt         <= w_cnt;
        end
    end

    // Next-state and next-datapath decode for the frame assembler.
    always_comb begin
        w_next_state  = r_state;
        w_pkt_valid   = r_pkt_valid;
        w_chk_error   = 1'b0;
        w_err_abort   = 1'b0;
        w_pkt_opcode  = r_pkt_opcode;
        w_pkt_payload = r_pkt_payload;
        w_chksum      = r_chksum;
        w_cnt         = r_cnt;

        case (r_state)
            IDLE: begin
                // Line errors are ignored here; non-sync bytes are acked and dropped.
                if (w_capture && (bus.rx_data == SYNC_BYTE)) begin
                    w_next_state = OPCODE;
                end else begin
                    w_next_state = IDLE;
                end
            end

            OPCODE, PAYLOAD, CHECK: begin
                // A line error wins over a byte captured on the same edge.
                if (w_line_err || w_timeout) begin
                    w_err_abort  = 1'b1;
                    w_next_state = IDLE;
                end else if (w_capture) begin
                    case (r_state)
                        OPCODE: begin
                            w_pkt_opcode = bus.rx_data;
                            w_chksum     = bus.rx_data;
                            w_cnt        = '0;
                            w_next_state = PAYLOAD;
                        end
                        PAYLOAD: begin
                            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                                w_pkt_payload[i*8 +: 8] = (r_cnt == CNT_W'(i)) ?
                                                          bus.rx_data : r_pkt_payload[i*8 +: 8];
                            end
                            w_chksum = r_chksum ^ bus.rx_data;
                            if (r_cnt == LAST_IDX) begin
                                w_next_state = CHECK;
                            end else begin
                                w_cnt = r_cnt + CNT_W'(1);
                            end
                        end
                        CHECK: begin
                            if (bus.rx_data == r_chksum) begin
                                w_pkt_valid  = 1'b1;
                                w_next_state = HOLD;
                            end else begin
                                w_chk_error  = 1'b1;
                                w_next_state = IDLE;
                            end
                        end
                        default: begin
                            w_next_state = IDLE;
                        end
                    endcase
                end else begin
                    w_next_state = r_state;
                end
            end

            HOLD: begin
                // Frame stays put until the consumer takes it.
                if (r_pkt_valid && bus.pkt_ready) begin
                    w_pkt_valid  = 1'b0;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = HOLD;
                end
            end

            default: begin
                w_pkt_valid  = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    assign bus.data_read   = r_data_read;
    assign bus.pkt_valid   = r_pkt_valid;
    assign bus.chk_error   = r_chk_error;
    assign bus.err_abort   = r_err_abort;
    assign bus.pkt_opcode  = r_pkt_opcode;
    assign bus.pkt_payload = r_pkt_payload;
endmodule

// File: tb/tb_rx_pkt_assembler.sv
// Directed bench for rx_pkt_assembler with a frame scoreboard.
module tb_rx_pkt_assembler;
    localparam int PB = 4;
    localparam int PW = 8 * PB;

    typedef struct packed {
        logic [7:0]    op;
        logic [PW-1:0] pl;
    } frame_t;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    rx_pkt_assembler_if #(.PAYLOAD_BYTES(PB)) bus ();

    rx_pkt_assembler #(
        .PAYLOAD_BYTES (PB),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    frame_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int chk_cnt = 0;
    int abort_cnt = 0;
    int xfer_cnt = 0;

    // Pulse and transfer counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.data_read) rd_cnt <= rd_cnt + 1;
            if (bus.chk_error) chk_cnt <= chk_cnt + 1;
            if (bus.err_abort) abort_cnt <= abort_cnt + 1;
            if (bus.pkt_valid && bus.pkt_ready) xfer_cnt <= xfer_cnt + 1;
        end
    end

    // Run-time guard so a stuck design cannot hang the run.
    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish within 300000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] op, input logic [PW-1:0] pl);
        logic [7:0] c;
        c = op;
        for (int i = 0; i < PB; i++) c = c ^ pl[i*8 +: 8];
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        bus.rx_data    = b;
        bus.data_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.data_read) seen = 1'b1;
        end
        check("byte_ack", seen, 1);
        // Buffer drops data_ready one cycle late, as a real UART buffer would.
        @(posedge clk); #1;
        bus.data_ready = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] op, input logic [PW-1:0] pl, input logic [7:0] bad);
        frame_t f;
        if (bad == 8'h00) begin
            f.op = op;
            f.pl = pl;
            sb_q.push_back(f);
        end
        send_byte(op);
        for (int i = 0; i < PB; i++) send_byte(pl[i*8 +: 8]);
        send_byte(xsum(op, pl) ^ bad);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [PW-1:0] pl, input logic [7:0] bad);
        send_byte(8'hA5);
        send_body(op, pl, bad);
    endtask

    task automatic release_frame();
        frame_t f;
        bit dropped;
        check("valid_before_xfer", bus.pkt_valid, 1);
        check("sb_has_entry", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            f = sb_q.pop_front();
            check("sb_opcode", bus.pkt_opcode, f.op);
            check("sb_payload", bus.pkt_payload, f.pl);
        end
        bus.pkt_ready = 1'b1;
        dropped = 1'b0;
        for (int i = 0; i < 5 && !dropped; i++) begin
            @(posedge clk); #1;
            if (!bus.pkt_valid) dropped = 1'b1;
        end
        check("valid_drop_after_xfer", dropped, 1);
        bus.pkt_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_read"}, bus.data_read, 0);
        check({tag, "_pkt_valid"}, bus.pkt_valid, 0);
        check({tag, "_chk_error"}, bus.chk_error, 0);
        check({tag, "_err_abort"}, bus.err_abort, 0);
        check({tag, "_pkt_opcode"}, bus.pkt_opcode, 0);
        check({tag, "_pkt_payload"}, bus.pkt_payload, 0);
    endtask

    initial begin
        int r0;
        int c0;
        int a0;
        n_rst             = 1'b0;
        bus.rx_data       = 8'h00;
        bus.data_ready    = 1'b0;
        bus.overrun_error = 1'b0;
        bus.framing_error = 1'b0;
        bus.pkt_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame A5 10 01 02 03 04 14.
        r0 = rd_cnt;
        send_frame(8'h10, 32'h04030201, 8'h00);
        check("f1_valid", bus.pkt_valid, 1);
        check("f1_opcode", bus.pkt_opcode, 8'h10);
        check("f1_payload", bus.pkt_payload, 32'h04030201);
        repeat (2) @(posedge clk);
        #1;
        check("f1_chk_error_count", chk_cnt, 0);
        check("f1_abort_count", abort_cnt, 0);
        check("f1_read_pulses", rd_cnt - r0, 7);

        // Backpressure: next byte waits 50 cycles while the frame is held.
        bus.rx_data    = 8'hA5;
        bus.data_ready = 1'b1;
        r0 = rd_cnt;
        repeat (50) @(posedge clk);
        #1;
        check("bp_no_read", rd_cnt - r0, 0);
        check("bp_data_read_low", bus.data_read, 0);
        check("bp_valid_held", bus.pkt_valid, 1);
        check("bp_opcode_stable", bus.pkt_opcode, 8'h10);
        check("bp_payload_stable", bus.pkt_payload, 32'h04030201);
        release_frame();
        check("bp_one_transfer", xfer_cnt, 1);
        send_byte(8'hA5);
        send_body(8'h22, 32'h44332211, 8'h00);
        release_frame();
        check("bp_read_pulses", rd_cnt - r0, 7);

        // Checksum 15 instead of 14.
        c0 = chk_cnt;
        send_frame(8'h10, 32'h04030201, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        check("badchk_pulse_count", chk_cnt - c0, 1);
        check("badchk_no_valid", bus.pkt_valid, 0);

        // Garbage before sync; sync value also used as opcode and payload data.
        r0 = rd_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'hA5, 32'h0C0BA50A, 8'h00);
        check("garbage_frame_valid", bus.pkt_valid, 1);
        release_frame();
        check("garbage_read_pulses", rd_cnt - r0, 9);

        // Framing error on the second payload byte aborts the frame.
        a0 = abort_cnt;
        send_byte(8'hA5);
        send_byte(8'h31);
        send_byte(8'h01);
        bus.framing_error = 1'b1;
        send_byte(8'h02);
        bus.framing_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("fe_abort_count", abort_cnt - a0, 1);
        check("fe_no_valid", bus.pkt_valid, 0);
        // Line errors in IDLE do not abort anything.
        bus.overrun_error = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.overrun_error = 1'b0;
        check("idle_err_no_abort", abort_cnt - a0, 1);
        send_frame(8'h40, 32'h80706050, 8'h00);
        release_frame();

        // Stall after the opcode.
        a0 = abort_cnt;
        send_byte(8'hA5);
        send_byte(8'h30);
`ifdef RX_PKT_TIMEOUT_EN
        repeat (98) @(posedge clk);
        #1;
        check("tmo_not_yet", abort_cnt - a0, 0);
        check("tmo_abort_low", bus.err_abort, 0);
        @(posedge clk); #1;
        check("tmo_abort_pulse", bus.err_abort, 1);
        repeat (2) @(posedge clk);
        #1;
        check("tmo_abort_count", abort_cnt - a0, 1);
`else
        repeat (150) @(posedge clk);
        #1;
        check("notmo_no_abort", abort_cnt - a0, 0);
        check("notmo_no_valid", bus.pkt_valid, 0);
        check("notmo_opcode_kept", bus.pkt_opcode, 8'h30);
`endif
        n_rst = 1'b0;
        #2;
        check_reset_outputs("midreset");
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h55, 32'h01020304, 8'h00);
        release_frame();

        check("sb_empty_at_end", sb_q.size(), 0);
        check("total_transfers", xfer_cnt, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
